// File: rtl/nios_setup_nios2f_cpu_mult_seq.sv
// nios_setup_nios2f_cpu_mult_seq
// Multi-cycle multiply sequencer wrapped around a 3-product 16x16 mult cell
// (lo*lo, lo*hi, hi*lo). It takes one MUL/MULX* request at a time and drives
// the cell with the full operands for the low pass. It folds p1/p2/p3 into
// the low word and, for MULX*, runs a second cell pass on the upper halves to
// build the high word. The 32-bit result is returned over valid/ready.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_op              00 MUL, 01 MULXSS, 10 MULXSU, 11 MULXUU
//   req_src1/2          operands A / B
//   cell_src1/2, en     operands and enable towards the mult cell
//   cell_p1/p2/p3       partial products returned by the cell
//   rsp_valid/ready     result handshake
//   rsp_result          MUL: product[31:0], MULX*: product[63:32]
//   busy                high whenever the sequencer is not idle
module nios_setup_nios2f_cpu_mult_seq #(
  parameter int CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE_LO, S_WAIT_LO, S_ISSUE_HI, S_WAIT_HI, S_RESP
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  // Wait counter is loaded with L-1 so the capture lands L edges after the
  // cell_en edge.
  localparam logic [1:0] CNT_INIT  = 2'(CELL_LATENCY - 1);

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [1:0]  r_op;
  logic [16:0] r_mid_hi;
  logic        r_c;
  logic [31:0] r_cell_src1;
  logic [31:0] r_cell_src2;
  logic        r_cell_en;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_result;

  // Cross terms A.lo*B.hi + A.hi*B.lo, kept at full 33-bit width.
  function automatic logic [32:0] f_mid(input logic [31:0] p2, input logic [31:0] p3);
    return {1'b0, p2} + {1'b0, p3};
  endfunction

  // Low word plus carry out into the high word.
  function automatic logic [32:0] f_lo(input logic [31:0] p1, input logic [32:0] mid);
    return {1'b0, p1} + {1'b0, mid[15:0], 16'h0000};
  endfunction

  // High word: unsigned high product, then sign corrections. A negative
  // signed operand contributes -2^32 * (other operand) to the product.
  function automatic logic [31:0] f_hi(input logic [1:0]  op,
                                       input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] hh,
                                       input logic [16:0] mid_hi,
                                       input logic        c);
    logic [31:0] hu;
    logic [31:0] corr_a;
    logic [31:0] corr_b;
    hu     = hh + {15'h0000, mid_hi} + {31'h0, c};
    corr_a = a[31] ? b : 32'h0;
    corr_b = b[31] ? a : 32'h0;
    case (op)
      OP_MULXSS: return hu - corr_a - corr_b;
      OP_MULXSU: return hu - corr_a;
      default:   return hu;
    endcase
  endfunction

  logic [32:0] w_mid;
  logic [32:0] w_lo;
  logic [31:0] w_hi;
  logic        w_accept;
  logic        w_lo_capture;

  assign w_mid        = f_mid(cell_p2, cell_p3);
  assign w_lo         = f_lo(cell_p1, w_mid);
  assign w_hi         = f_hi(r_op, r_a, r_b, cell_p1, r_mid_hi, r_c);
  assign w_accept     = (r_state == S_IDLE) && req_valid;
  assign w_lo_capture = (r_state == S_WAIT_LO) && (r_cnt == 2'd0);

  // Operand / intermediate holding registers (no reset needed: only read
  // after being written by an accepted request).
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a  <= req_src1;
      r_b  <= req_src2;
      r_op <= req_op;
    end
    if (w_lo_capture) begin
      r_mid_hi <= w_mid[32:16];
      r_c      <= w_lo[32];
    end
  end

  // Sequencer FSM with registered cell and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 2'd0;
      r_cell_src1  <= 32'h0;
      r_cell_src2  <= 32'h0;
      r_cell_en    <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_cell_src1 <= req_src1;
            r_cell_src2 <= req_src2;
            r_cell_en   <= 1'b1;
            r_state     <= S_ISSUE_LO;
          end
        end
        S_ISSUE_LO: begin
          r_cell_en <= 1'b0;
          r_cnt     <= CNT_INIT;
          r_state   <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
          end else if (r_op == OP_MUL) begin
            r_rsp_result <= w_lo[31:0];
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cell_src1 <= {16'h0000, r_a[31:16]};
            r_cell_src2 <= {16'h0000, r_b[31:16]};
            r_cell_en   <= 1'b1;
            r_state     <= S_ISSUE_HI;
          end
        end
        S_ISSUE_HI: begin
          r_cell_en <= 1'b0;
          r_cnt     <= CNT_INIT;
          r_state   <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
          end else begin
            r_rsp_result <= w_hi;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign cell_src1  = r_cell_src1;
  assign cell_src2  = r_cell_src2;
  assign cell_en    = r_cell_en;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;

endmodule

// File: tb/tb_nios_setup_nios2f_cpu_mult_seq.sv
// Bench for nios_setup_nios2f_cpu_mult_seq with a behavioural 1-cycle mult
// cell. Stimulus pushes expected results into a scoreboard queue; a monitor
// checks latency, cell pass count and result on each response.
module tb_nios_setup_nios2f_cpu_mult_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic [31:0] cell_src1;
  logic [31:0] cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1;
  logic [31:0] cell_p2;
  logic [31:0] cell_p3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        busy;

  nios_setup_nios2f_cpu_mult_seq #(.CELL_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2),
    .cell_src1(cell_src1), .cell_src2(cell_src2), .cell_en(cell_en),
    .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Mult cell model: registers the three partial products when enabled.
  always @(posedge clk) begin
    if (cell_en) begin
      cell_p1 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[15:0]};
      cell_p2 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[31:16]};
      cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          npass;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   stall_mode = 0;  // 0: always ready, 1: random, 2: hold low

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // 64-bit reference: extend operands per signedness, multiply, pick word.
  function automatic logic [31:0] ref_mul(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (op == 2'b01)                ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      $display("FAIL req_ready_timeout: got %b, expected 1", req_ready);
      $fatal(1, "sequencer never returned to idle");
    end
  endtask

  // Issue one op; push its expectation unless it is going to be dropped.
  task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                       logic [31:0] exp_res, bit push);
    exp_t e;
    wait_ready();
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    if (push) begin
      e.res   = exp_res;
      e.lat   = (op == 2'b00) ? 2 : 4;
      e.npass = (op == 2'b00) ? 1 : 2;
      e.acc   = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    // Scramble the request after acceptance; the op in flight must not care.
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_src1  = $urandom;
    req_src2  = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || req_ready !== 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", 32'(q.size()), 32'd0);
  endtask

  // rsp_ready changes just after the rising edge only.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (stall_mode)
        1:       rsp_ready = 1'($urandom_range(0, 1));
        2:       rsp_ready = 1'b0;
        default: rsp_ready = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard checker.
  initial begin
    bit   prev_v  = 1'b0;
    bit   prev_en = 1'b0;
    int   en_cnt  = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        prev_v  = 1'b0;
        prev_en = 1'b0;
        en_cnt  = 0;
      end else begin
        if (cell_en === 1'b1) begin
          en_cnt++;
          chk("cell_en_single_cycle", {31'h0, prev_en}, 32'h0);
        end
        if (rsp_valid === 1'b1 && !prev_v) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 result %h, expected no response", rsp_result);
          end else begin
            chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
            chk("cell_passes", 32'(en_cnt), 32'(q[0].npass));
          end
          en_cnt = 0;
        end
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1 && q.size() != 0) begin
          e = q.pop_front();
          chk("result", rsp_result, e.res);
        end
        prev_v  = (rsp_valid === 1'b1);
        prev_en = (cell_en === 1'b1);
      end
    end
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] edge_v [4];
    int          n;
    edge_v[0] = 32'h0000_0000; edge_v[1] = 32'hFFFF_FFFF;
    edge_v[2] = 32'h8000_0000; edge_v[3] = 32'h7FFF_FFFF;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_src1  = 32'h0;
    req_src2  = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready",  {31'h0, req_ready}, 32'h1);
    chk("reset_rsp_valid",  {31'h0, rsp_valid}, 32'h0);
    chk("reset_cell_en",    {31'h0, cell_en},   32'h0);
    chk("reset_busy",       {31'h0, busy},      32'h0);
    chk("reset_rsp_result", rsp_result,         32'h0);
    chk("reset_cell_src1",  cell_src1,          32'h0);
    chk("reset_cell_src2",  cell_src2,          32'h0);
    reset = 1'b0;

    // (2^16+3)(2^17+5) = 2^33 + 11*2^16 + 15
    issue(2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b1);
    // (2^32-1)^2 = 2^64 - 2^33 + 1
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    // -1 * 2 = -2: high word all ones for both signed-A forms
    issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1);
    issue(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1);
    // unsigned 0xFFFFFFFF*2 = 0x1_FFFFFFFE
    issue(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b1);
    drain();
    chk("idle_busy", {31'h0, busy}, 32'h0);

    // (-2^31)^2 = 2^62, then hold the response under backpressure.
    stall_mode = 2;
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("stall_result",    rsp_result,         32'h4000_0000);
      chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
      @(negedge clk);
    end
    stall_mode = 0;
    drain();

    // Reset while the high pass is in WAIT_HI; the op must vanish.
    issue(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("dropped_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    end
    issue(2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b1);
    issue(2'b10, 32'h8000_0000, 32'h0000_0003, ref_mul(2'b10, 32'h8000_0000, 32'h0000_0003), 1'b1);
    drain();

    // Random ops with random backpressure against the 64-bit model.
    stall_mode = 1;
    for (int i = 0; i < 400; i++) begin
      op = 2'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
      issue(op, a, b, ref_mul(op, a, b), 1'b1);
    end
    drain();
    stall_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
